// File: rtl/shift_pkg.sv
// Shared types for the operand-2 shifter: shift/mode encodings, the decoded
// request carried between pipeline stages, and the instruction-field decoder.
package shift_pkg;

  localparam int MAX_W = 64;
  localparam int AMT_W = 8;

  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROR = 2'b11
  } shift_type_e;

  typedef enum logic [1:0] {
    MODE_MEM = 2'd0,
    MODE_IMM = 2'd1,
    MODE_REG = 2'd2,
    MODE_RRX = 2'd3
  } mode_e;

  typedef struct packed {
    mode_e             mode;
    shift_type_e       stype;
    logic [AMT_W-1:0]  amount;
    logic [MAX_W-1:0]  rm;
    logic              c_in;
  } shift_req_t;

  // Memory-offset and immediate operands are folded into the generic shifter:
  // both become "shift rm by amount", so only RRX needs a dedicated path.
  function automatic shift_req_t decode_req(input int               data_w,
                                            input logic [MAX_W-1:0] rm,
                                            input logic [AMT_W-1:0] rs_amt,
                                            input logic [11:0]      op,
                                            input logic             imm,
                                            input logic             is_mem,
                                            input logic             c_in);
    shift_req_t req;
    req.mode   = MODE_REG;
    req.stype  = shift_type_e'(op[6:5]);
    req.amount = '0;
    req.rm     = rm;
    req.c_in   = c_in;
    if (is_mem) begin
      req.mode  = MODE_MEM;
      req.stype = SH_LSL;
      req.rm    = MAX_W'(op);
    end else if (imm) begin
      req.mode   = MODE_IMM;
      req.stype  = SH_ROR;
      req.rm     = MAX_W'(op[7:0]);
      req.amount = {3'b000, op[11:8], 1'b0};
    end else if (op[4]) begin
      req.amount = rs_amt;
    end else if (op[11:7] != 5'd0) begin
      req.amount = {3'b000, op[11:7]};
    end else begin
      // Immediate amount 0 encodes LSR/ASR #DATA_W and RRX; LSL #0 is a pass.
      case (req.stype)
        SH_LSR, SH_ASR: req.amount = AMT_W'(data_w);
        SH_ROR:         req.mode   = MODE_RRX;
        default:        ;
      endcase
    end
    return req;
  endfunction

endpackage

// File: rtl/barrel_shift_core.sv
// Combinational barrel shifter: turns a decoded request into val2 and the
// shifter carry-out. Amount 0 always passes rm through with the incoming carry.
module barrel_shift_core
  import shift_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  shift_req_t        req,
  output logic [DATA_W-1:0] val2,
  output logic              c_out
);

  localparam int RW = $clog2(DATA_W);
  localparam logic [AMT_W-1:0] WIDTH_AMT = AMT_W'(DATA_W);

  logic [DATA_W-1:0]          rm;
  logic [2*DATA_W-1:0]        lsl_wide;
  logic [2*DATA_W-1:0]        lsr_wide;
  logic signed [2*DATA_W-1:0] asr_wide;
  logic [AMT_W-1:0]           asr_amt;
  logic [RW-1:0]              rot;
  logic [RW:0]                rot_inv;
  logic [DATA_W-1:0]          ror_val;

  assign rm = req.rm[DATA_W-1:0];

  // Double-width shifts keep the last bit shifted out next to the result.
  assign lsl_wide = {{DATA_W{1'b0}}, rm} << req.amount;
  assign lsr_wide = {rm, {DATA_W{1'b0}}} >> req.amount;
  assign asr_amt  = (req.amount > WIDTH_AMT) ? WIDTH_AMT : req.amount;
  assign asr_wide = $signed({rm, {DATA_W{1'b0}}}) >>> asr_amt;
  assign rot      = req.amount[RW-1:0];
  assign rot_inv  = (RW+1)'(DATA_W) - {1'b0, rot};
  assign ror_val  = (rm >> rot) | (rm << rot_inv);

  // NOTE: every output gets a default first so no path through the case
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    val2  = rm;
    c_out = req.c_in;
    if (req.mode == MODE_RRX) begin
      val2  = {req.c_in, rm[DATA_W-1:1]};
      c_out = rm[0];
    end else if (req.amount != '0) begin
      case (req.stype)
        SH_LSL: begin
          val2  = lsl_wide[DATA_W-1:0];
          c_out = lsl_wide[DATA_W];
        end
        SH_LSR: begin
          val2  = lsr_wide[2*DATA_W-1:DATA_W];
          c_out = lsr_wide[DATA_W-1];
        end
        SH_ASR: begin
          val2  = asr_wide[2*DATA_W-1:DATA_W];
          c_out = asr_wide[DATA_W-1];
        end
        default: begin
          val2  = ror_val;
          c_out = ror_val[DATA_W-1];
        end
      endcase
    end
  end

  logic unused_wide;
  assign unused_wide = ^{lsl_wide[2*DATA_W-1:DATA_W+1], lsr_wide[DATA_W-2:0],
                         asr_wide[DATA_W-2:0]};

  if (DATA_W < MAX_W) begin : g_rm_pad
    logic unused_rm_hi;
    assign unused_rm_hi = ^req.rm[MAX_W-1:DATA_W];
  end

endmodule

// File: rtl/shift_operand_unit.sv
// Operand-2 unit: decodes the instruction operand field, shifts through
// barrel_shift_core and delivers the result over a valid/ready pipeline.
module shift_operand_unit
  import shift_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] rm,
  input  logic [DATA_W-1:0] rs,
  input  logic [11:0]       shift_operand,
  input  logic              imm,
  input  logic              is_mem_command,
  input  logic              c_in,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] val2_out,
  output logic              c_out
);

  shift_req_t        dec_req;
  shift_req_t        core_req;
  logic              core_v;
  logic [DATA_W-1:0] core_val2;
  logic              core_c;
  logic              stage_ready;
  logic              in_fire;
  logic              out_adv;

  logic              out_v_q, out_v_d;
  logic [DATA_W-1:0] val2_q, val2_d;
  logic              c_q, c_d;

  assign dec_req = decode_req(DATA_W, MAX_W'(rm), rs[AMT_W-1:0], shift_operand,
                              imm, is_mem_command, c_in);

  assign out_adv  = !out_v_q || out_ready;
  assign in_ready = !rst && stage_ready;
  assign in_fire  = in_valid && in_ready;

  if (LATENCY == 2) begin : g_stage1
    logic       s1_v_q, s1_v_d;
    shift_req_t s1_req_q, s1_req_d;
    logic       s1_adv;

    assign s1_adv      = !s1_v_q || out_adv;
    assign stage_ready = s1_adv;
    assign core_v      = s1_v_q;
    assign core_req    = s1_req_q;

    always_comb begin
      s1_v_d   = s1_v_q;
      s1_req_d = s1_req_q;
      if (flush) begin
        s1_v_d = 1'b0;
      end else if (s1_adv) begin
        s1_v_d = in_fire;
        if (in_fire) s1_req_d = dec_req;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s1_v_q   <= 1'b0;
        s1_req_q <= '0;
      end else begin
        s1_v_q   <= s1_v_d;
        s1_req_q <= s1_req_d;
      end
    end
  end else begin : g_direct
    assign stage_ready = out_adv;
    assign core_v      = in_fire;
    assign core_req    = dec_req;
  end

  barrel_shift_core #(.DATA_W(DATA_W)) u_core (
    .req   (core_req),
    .val2  (core_val2),
    .c_out (core_c)
  );

  // Result registers only load on an advancing, valid stage so a stalled
  // output holds its value.
  always_comb begin
    out_v_d = out_v_q;
    val2_d  = val2_q;
    c_d     = c_q;
    if (flush) begin
      out_v_d = 1'b0;
    end else if (out_adv) begin
      out_v_d = core_v;
      if (core_v) begin
        val2_d = core_val2;
        c_d    = core_c;
      end
    end
  end

  // NOTE: state updates use non-blocking assignments so every flop samples
  // the pre-edge values; the data registers are reset too because the
  // outputs must read zero during reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_v_q <= 1'b0;
      val2_q  <= '0;
      c_q     <= 1'b0;
    end else begin
      out_v_q <= out_v_d;
      val2_q  <= val2_d;
      c_q     <= c_d;
    end
  end

  assign out_valid = out_v_q;
  assign val2_out  = val2_q;
  assign c_out     = c_q;

  logic unused_rs;
  assign unused_rs = ^rs[DATA_W-1:AMT_W];

endmodule

// File: tb/tb_shift_operand_unit.sv
// Drives three shift_operand_unit variants (32/L2, 32/L1, 64/L2) in lockstep
// and compares each result stream with a bit-serial reference model.
module tb_shift_operand_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, flush, out_ready, imm, mem, cin;
  logic [63:0] rm64, rs64;
  logic [11:0] op;

  logic        rdy_a, ov_a, c_a, rdy_b, ov_b, c_b, rdy_w, ov_w, c_w;
  logic [31:0] v_a, v_b;
  logic [63:0] v_w;

  shift_operand_unit #(.DATA_W(32), .LATENCY(2)) u_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_a),
    .rm(rm64[31:0]), .rs(rs64[31:0]), .shift_operand(op), .imm(imm),
    .is_mem_command(mem), .c_in(cin), .flush(flush), .out_valid(ov_a),
    .out_ready(out_ready), .val2_out(v_a), .c_out(c_a));

  shift_operand_unit #(.DATA_W(32), .LATENCY(1)) u_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_b),
    .rm(rm64[31:0]), .rs(rs64[31:0]), .shift_operand(op), .imm(imm),
    .is_mem_command(mem), .c_in(cin), .flush(flush), .out_valid(ov_b),
    .out_ready(out_ready), .val2_out(v_b), .c_out(c_b));

  shift_operand_unit #(.DATA_W(64), .LATENCY(2)) u_w (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_w),
    .rm(rm64), .rs(rs64), .shift_operand(op), .imm(imm),
    .is_mem_command(mem), .c_in(cin), .flush(flush), .out_valid(ov_w),
    .out_ready(out_ready), .val2_out(v_w), .c_out(c_w));

  logic        ov  [3];
  logic        rdy [3];
  logic [64:0] obs [3];

  always_comb begin
    ov[0] = ov_a;  rdy[0] = rdy_a;  obs[0] = {c_a, 32'd0, v_a};
    ov[1] = ov_b;  rdy[1] = rdy_b;  obs[1] = {c_b, 32'd0, v_b};
    ov[2] = ov_w;  rdy[2] = rdy_w;  obs[2] = {c_w, v_w};
  end

  logic [64:0] expq [3][$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_fail   = 0;
  logic        ovr_en   = 1'b0;
  logic [64:0] ovr      = '0;
  logic        acc;

  task automatic check(input string tag, input logic [64:0] got, input logic [64:0] want);
    n_checks++;
    assert (got === want) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  // Reference: shifts one bit at a time, carry is simply the last bit that fell out.
  function automatic logic [64:0] model(input int w, input logic [63:0] rm_i,
                                        input logic [63:0] rs_i, input logic [11:0] op_i,
                                        input logic imm_i, input logic mem_i, input logic cin_i);
    logic [63:0] mask;
    logic [63:0] v;
    logic        c, b;
    int          a, t;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    v = rm_i & mask;
    c = cin_i;
    if (mem_i) return {cin_i, 52'd0, op_i};
    if (imm_i) begin
      v = {56'd0, op_i[7:0]};
      a = 2 * int'(op_i[11:8]);
      for (int i = 0; i < a; i++) begin
        b = v[0];
        v = (v >> 1) | (64'(b) << (w - 1));
      end
      return {(a == 0) ? cin_i : v[w-1], v};
    end
    t = int'(op_i[6:5]);
    a = op_i[4] ? int'(rs_i[7:0]) : int'(op_i[11:7]);
    if (!op_i[4] && a == 0) begin
      case (t)
        0:       return {cin_i, v};
        1, 2:    a = w;
        default: return {v[0], (v >> 1) | (64'(cin_i) << (w - 1))};
      endcase
    end
    for (int i = 0; i < a; i++) begin
      case (t)
        0: begin c = v[w-1]; v = (v << 1) & mask; end
        1: begin c = v[0];   v = v >> 1; end
        2: begin c = v[0];   b = v[w-1]; v = (v >> 1) | (64'(b) << (w - 1)); end
        default: begin c = v[0]; v = (v >> 1) | (64'(c) << (w - 1)); end
      endcase
    end
    return {c, v};
  endfunction

  task automatic observe(input logic presented);
    logic [64:0] e;
    for (int d = 0; d < 3; d++) begin
      if (ov[d]) begin
        check($sformatf("spurious_out%0d", d), 65'(expq[d].size() != 0), 65'd1);
        if (expq[d].size() != 0) begin
          check($sformatf("result%0d", d), obs[d], expq[d][0]);
          if (out_ready) void'(expq[d].pop_front());
        end
      end
    end
    if (flush) begin
      for (int d = 0; d < 3; d++) expq[d].delete();
    end else if (presented) begin
      for (int d = 0; d < 3; d++) begin
        e = model((d == 2) ? 64 : 32, rm64, rs64, op, imm, mem, cin);
        if (ovr_en && d < 2) e = ovr;
        expq[d].push_back(e);
      end
    end
  endtask

  // One clock: inputs already set at posedge+1, outputs sampled at negedge.
  task automatic send_cycle(input logic want, input logic ordy, input logic fl,
                            output logic accepted);
    out_ready = ordy;
    flush     = fl;
    #1;
    accepted = want && rdy[0] && rdy[1] && rdy[2];
    in_valid = accepted;
    @(negedge clk);
    observe(accepted);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic send_req();
    logic a;
    a = 1'b0;
    for (int i = 0; i < 50 && !a; i++) send_cycle(1'b1, 1'b1, 1'b0, a);
    check("accept_timeout", 65'(a), 65'd1);
  endtask

  task automatic directed(input logic [31:0] r, input logic [31:0] s, input logic [11:0] o,
                          input logic im, input logic me, input logic ci,
                          input logic [31:0] ev, input logic ec);
    rm64 = {32'd0, r}; rs64 = {32'd0, s}; op = o; imm = im; mem = me; cin = ci;
    ovr_en = 1'b1;
    ovr    = {ec, 32'd0, ev};
    send_req();
    ovr_en = 1'b0;
  endtask

  task automatic randomize_fields();
    rm64 = {$urandom, $urandom};
    rs64 = {$urandom, $urandom};
    if ($urandom_range(0, 1) == 1) rs64[7:0] = 8'($urandom_range(0, 70));
    op  = 12'($urandom);
    imm = ($urandom_range(0, 3) == 0);
    mem = ($urandom_range(0, 5) == 0);
    cin = 1'($urandom);
  endtask

  task automatic drain(input int n);
    logic a;
    repeat (n) send_cycle(1'b0, 1'b1, 1'b0, a);
  endtask

  task automatic check_reset_state(input string tag);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("%s_out_valid%0d", tag, d), 65'(ov[d]), 65'd0);
      check($sformatf("%s_result%0d", tag, d), obs[d], 65'd0);
      check($sformatf("%s_in_ready%0d", tag, d), 65'(rdy[d]), 65'd0);
    end
  endtask

  task automatic check_empty(input string tag);
    for (int d = 0; d < 3; d++)
      check($sformatf("%s_leftover%0d", tag, d), 65'(expq[d].size()), 65'd0);
  endtask

  task automatic reset_full_pipe(input string tag);
    logic a;
    repeat (3) begin
      randomize_fields();
      send_cycle(1'b1, 1'b0, 1'b0, a);
    end
    #2;
    rst = 1'b1;
    #1;
    check_reset_state(tag);
    for (int d = 0; d < 3; d++) expq[d].delete();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    drain(6);
  endtask

  initial begin
    int k, sent;
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    rm64 = '0; rs64 = '0; op = '0; imm = 1'b0; mem = 1'b0; cin = 1'b0;
    #2;
    check_reset_state("reset");
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed vectors, including amount boundaries.
    directed(32'h0000_00FF, 32'h0,  12'h200, 1'b0, 1'b0, 1'b0, 32'h0000_0FF0, 1'b0);
    directed(32'h1234_5678, 32'h0,  12'h4FF, 1'b1, 1'b0, 1'b0, 32'hFF00_0000, 1'b1);
    directed(32'h0000_0003, 32'h0,  12'h060, 1'b0, 1'b0, 1'b1, 32'h8000_0001, 1'b1);
    directed(32'hFFFF_FFFF, 32'h21, 12'h030, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0);
    directed(32'hFFFF_FFFF, 32'h21, 12'h050, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b1);
    directed(32'h8000_0000, 32'h0,  12'h020, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b1);
    directed(32'h0000_0001, 32'h20, 12'h010, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b1);
    directed(32'h8000_0001, 32'h40, 12'h070, 1'b0, 1'b0, 1'b0, 32'h8000_0001, 1'b1);
    directed(32'h8000_0000, 32'h0,  12'h050, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 1'b0);
    directed(32'hDEAD_BEEF, 32'h0,  12'hABC, 1'b1, 1'b1, 1'b1, 32'h0000_0ABC, 1'b1);
    directed(32'hDEAD_BEEF, 32'h0,  12'h0AB, 1'b1, 1'b0, 1'b1, 32'h0000_00AB, 1'b1);
    drain(5);
    check_empty("directed");

    // Eight-request stream, out_ready 1,0,0,1 repeating, flush on cycle 5.
    k = 0; sent = 0;
    randomize_fields();
    while (sent < 8 && k < 60) begin
      send_cycle(1'b1, (k % 4 == 0) || (k % 4 == 3), k == 5, acc);
      if (acc) begin
        sent++;
        randomize_fields();
      end
      k++;
    end
    check("stream_timeout", 65'(sent), 65'd8);
    drain(6);
    check_empty("stream");

    // Randomized traffic with backpressure and occasional flushes.
    repeat (400) begin
      randomize_fields();
      send_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 31) == 0, acc);
    end
    drain(6);
    check_empty("random");

    // Reset with the pipeline full, then confirm normal operation resumes.
    reset_full_pipe("midreset");
    check_empty("post_reset");
    repeat (40) begin
      randomize_fields();
      send_cycle(1'b1, $urandom_range(0, 1) == 1, 1'b0, acc);
    end
    drain(6);
    check_empty("final");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/shift_operand_unit.md
SHIFT_OPERAND_UNIT -- requirements
Module: shift_operand_unit

Interface
REQ-001 Parameter DATA_W, default 32, datapath width; legal values 16, 32 or 64.
REQ-002 Parameter LATENCY, default 2, register stages from input to output; legal values 1 or 2.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  unit accepts the request this cycle.
REQ-007 rm  input  DATA_W  operand register value.
REQ-008 rs  input  DATA_W  shift-amount register value; only rs[7:0] is used.
REQ-009 shift_operand  input  12  instruction operand field.
REQ-010 imm  input  1  immediate-operand mode.
REQ-011 is_mem_command  input  1  memory-offset mode.
REQ-012 c_in  input  1  current carry flag.
REQ-013 flush  input  1  synchronous pipeline kill.
REQ-014 out_valid  output  1  result present.
REQ-015 out_ready  input  1  consumer accepts the result.
REQ-016 val2_out  output  DATA_W  operand-2 result.
REQ-017 c_out  output  1  shifter carry-out.

Function
REQ-018 A request transfers when in_valid && in_ready; a result transfers when out_valid && out_ready.
REQ-019 Mode priority is is_mem_command, then imm, then register.
- is_mem_command: val2 = zero-extended shift_operand[11:0]; c_out = c_in.
- imm: val2 = zero-extended shift_operand[7:0] rotated right by 2*shift_operand[11:8], modulo DATA_W.
  - Rotation 0: c_out = c_in.
  - Otherwise: c_out = val2[DATA_W-1].
REQ-020 Register mode uses type T = shift_operand[6:5] (00 LSL, 01 LSR, 10 ASR, 11 ROR).
- Amount source: shift_operand[4]=0 gives immediate amount A = shift_operand[11:7]; shift_operand[4]=1 gives A = rs[7:0].
REQ-021 Immediate amount A = 0 special cases:
- LSL: val2 = rm; c_out = c_in.
- LSR: treated as A = DATA_W.
- ASR: treated as A = DATA_W.
- ROR: performs RRX, val2 = {c_in, rm[DATA_W-1:1]}; c_out = rm[0].
REQ-022 Register amount A = 0: val2 = rm and c_out = c_in for every type.
REQ-023 Amount 0 < A < DATA_W: standard LSL, LSR, ASR or ROR; c_out = last bit shifted out.
REQ-024 Amount A = DATA_W:
- LSL: val2 = 0; c_out = rm[0].
- LSR: val2 = 0; c_out = rm[DATA_W-1].
- ASR: all bits = rm[DATA_W-1]; c_out = rm[DATA_W-1].
REQ-025 Amount A > DATA_W:
- LSL and LSR: val2 = 0; c_out = 0.
- ASR: same result as A = DATA_W.
- ROR: amount taken as A mod DATA_W; a result of 0 gives val2 = rm and c_out = rm[DATA_W-1].
REQ-026 Pipelining by LATENCY:
- LATENCY=1: the result is registered once; out_valid rises the cycle after acceptance.
- LATENCY=2: stage 1 registers the decoded mode, type, effective amount and operands; stage 2 registers the result.
REQ-027 Full throughput of one result per cycle with no bubbles while out_ready=1.
REQ-028 Backpressure:
- out_valid && !out_ready holds val2_out and c_out stable.
- in_ready = !(every stage valid && !out_ready); each stage advances only when the stage downstream is empty or advancing.
REQ-029 flush=1 clears every stage valid at the next edge and drops any concurrent input; flush overrides acceptance.
REQ-030 Simultaneous accept and output transfer on a full pipeline is legal and loses no data.

Reset
REQ-031 rst=1 immediately clears all valid bits and sets out_valid=0, val2_out=0 and c_out=0.
REQ-032 During rst=1, in_ready=0.
REQ-033 Reset asserted mid-transfer discards all in-flight requests; no partial result appears after release.

Structure
REQ-034 Shared package shift_pkg holds the shift-type encoding (LSL/LSR/ASR/ROR), mode encoding, and the decoded-request struct (mode, type, amount, rm, c_in).
REQ-035 Purely combinational sub-module barrel_shift_core(DATA_W) computes val2 and c_out from the decoded request; shift_operand_unit owns the decode, the pipeline registers and the handshake.

Verification
REQ-036 Register LSL #4, rm=0x0000_00FF -> val2=0x0000_0FF0, c_out=0.
REQ-037 imm=1, shift_operand=0x4FF -> val2=0xFF00_0000, c_out=1.
REQ-038 Immediate ROR #0 (RRX), c_in=1, rm=0x0000_0003 -> val2=0x8000_0001, c_out=1.
REQ-039 Register mode, rs=0x21, LSR, rm=0xFFFF_FFFF -> val2=0, c_out=0; same request with ASR -> val2=0xFFFF_FFFF, c_out=1.
REQ-040 Stream of 8 requests with out_ready toggling 1,0,0,1… plus flush on cycle 5 -> every accepted, unflushed result appears once, in order; the output is stable while stalled and nothing dropped by the flush appears.
REQ-041 rst pulse while the pipeline is full -> out_valid=0 immediately and no stale result after release; run for both LATENCY=1 and LATENCY=2 and for DATA_W=64.
